pattern_gen_check: RTL

Parametrised, synthesisable stimulus generator and response checker for block-level loopback tests. It drives a WIDTH-bit word stream on data_out and compares data_in against the same stream delayed by LATENCY cycles. It counts mismatches and records the index of the first mismatching word. It replaces the hand-written 1-bit clk/data_in/data_out test shells with one configurable block instantiated around the DUT.

---
 rtl/pattern_gen_check.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_gen_check.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen_check
// Description : Loopback stimulus generator and response checker. Drives a
//               counter or Galois-LFSR word stream on data_out and compares
//               data_in against the same stream delayed by LATENCY cycles,
//               counting mismatches and recording the first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen_check #(
  parameter int               WIDTH     = 8,
  parameter int               NUM_WORDS = 16,
  parameter int               LATENCY   = 1,
  parameter int               MODE      = 0,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(8'hB8),
  parameter int               ERR_W     = 8,
  localparam int              IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx
);

  // An all-zero LFSR state would lock up, so a zero seed becomes 1 in LFSR mode.
  localparam logic [WIDTH-1:0] c_seed_eff = ((MODE == 1) && (SEED == '0)) ? WIDTH'(1) : SEED;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_WORDS - 1);
  localparam logic [ERR_W-1:0] c_err_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start_run;
  logic [WIDTH-1:0]   w_next_word;
  logic [IDX_W-1:0]   r_idx;

  // Expected pipeline; element 0 is the first stage, LATENCY-1 the compare stage.
  logic [LATENCY-1:0] r_pipe_vld;
  logic [WIDTH-1:0]   r_pipe_word [LATENCY];
  logic [IDX_W-1:0]   r_pipe_idx  [LATENCY];

  logic               w_mismatch;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start is only honoured while idle or finished.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (r_idx == c_last_idx) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_pipe_vld == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Successor of the word currently on data_out.
  always_comb begin
    w_next_word = data_out + WIDTH'(1);
    if (MODE == 1) begin
      w_next_word = (data_out >> 1) ^ (data_out[0] ? POLY : '0);
    end
  end

  // Word generator: data_out doubles as the generator register and holds its
  // final word once the run has been emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      r_idx     <= '0;
    end else if (w_start_run) begin
      data_out  <= c_seed_eff;
      valid_out <= 1'b1;
      r_idx     <= '0;
    end else if (r_state == S_RUN) begin
      if (r_idx == c_last_idx) begin
        valid_out <= 1'b0;
      end else begin
        data_out  <= w_next_word;
        valid_out <= 1'b1;
        r_idx     <= r_idx + IDX_W'(1);
      end
    end
  end

  // Expected-word delay line, flushed at the start of every run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_word[i] <= '0;
        r_pipe_idx[i]  <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_pipe_word[i] <= r_pipe_word[i-1];
        r_pipe_idx[i]  <= r_pipe_idx[i-1];
      end
      r_pipe_word[0] <= data_out;
      r_pipe_idx[0]  <= r_idx;
      if (w_start_run) begin
        r_pipe_vld <= '0;
      end else begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
        r_pipe_vld[0] <= valid_out;
      end
    end
  end

  assign w_mismatch = r_pipe_vld[LATENCY-1] && (data_in != r_pipe_word[LATENCY-1]);

  // Error bookkeeping: saturating count plus sticky first-failure index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (w_start_run) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (w_mismatch) begin
      if (err_count != c_err_max) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= r_pipe_idx[LATENCY-1];
      end
    end
  end

  // Registered status flags, decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      done <= (w_state_nxt == S_DONE);
    end
  end

endmodule
`default_nettype wire
